// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, glitch/parity/framing/break detection
// and a first-word-fall-through output FIFO with valid/ready handshake.
module uart_rx_fifo #(
    parameter int pMAX_BITS    = 9,
    parameter int pFIFO_DEPTH  = 16,
    parameter int pSYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [15:0]                    bit_rate,
    input  logic [3:0]                     data_bits,
    input  logic [1:0]                     stop_bits,
    input  logic                           parity_bit,
    input  logic                           parity_enabled,
    input  logic                           parity_accept_errors,
    input  logic                           rxd,
    output logic [pMAX_BITS-1:0]           m_data,
    output logic [2:0]                     m_flags,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(pFIFO_DEPTH):0]   fifo_count,
    output logic                           overrun,
    input  logic                           clear_overrun,
    output logic [15:0]                    discard_count,
    output logic                           busy
);
    localparam int AW = $clog2(pFIFO_DEPTH);
    localparam int WW = pMAX_BITS + 3;
    localparam logic [AW:0] DEPTH = (AW+1)'(pFIFO_DEPTH);
    localparam logic [3:0]  MAXB  = 4'(pMAX_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAITH  = 3'd5;

    // Synchroniser resets high so reset release never looks like a start edge
    logic [pSYNC_STAGES-1:0] sync_q;
    logic                    prev_q;
    logic                    rxd_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[pSYNC_STAGES-2:0], rxd};
            prev_q <= rxd_s;
        end
    end
    assign rxd_s = sync_q[pSYNC_STAGES-1];

    logic [2:0]           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d, br_q, br_d, half;
    logic [3:0]           nb_q, nb_d, idx_q, idx_d;
    logic                 sb2_q, sb2_d, pen_q, pen_d, podd_q, podd_d, acc_q, acc_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 par_q, par_d, zero_q, zero_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [pMAX_BITS-1:0] data_q, data_d;
    logic                 vote, s_vote, bit_end, last_stop;
    logic                 push, discard;
    logic [WW-1:0]        push_word;

    assign half      = {1'b0, br_q[15:1]};
    assign s_vote    = (cnt_q == half + 16'd1);
    assign bit_end   = (cnt_q == br_q - 16'd1);
    assign vote      = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);
    assign last_stop = (idx_q == {3'b000, sb2_q});

    always_comb begin
        state_d = state_q;  cnt_d  = bit_end ? 16'd0 : cnt_q + 16'd1;
        br_d    = br_q;     nb_d   = nb_q;   idx_d  = idx_q;
        sb2_d   = sb2_q;    pen_d  = pen_q;  podd_d = podd_q; acc_d = acc_q;
        s0_d    = s0_q;     s1_d   = s1_q;
        par_d   = par_q;    zero_d = zero_q; perr_d = perr_q; ferr_d = ferr_q;
        data_d  = data_q;
        push    = 1'b0;     discard = 1'b0;  push_word = '0;
        if (cnt_q == half - 16'd1) s0_d = rxd_s;
        if (cnt_q == half)         s1_d = rxd_s;
        case (state_q)
            S_IDLE: begin
                if (prev_q && !rxd_s) begin
                    // Detection cycle is count 0 of the start bit; latch config here only
                    state_d = S_START;
                    cnt_d   = 16'd1;
                    br_d    = (bit_rate < 16'd4) ? 16'd4 : bit_rate;
                    nb_d    = (data_bits < 4'd5) ? 4'd5 : (data_bits > MAXB) ? MAXB : data_bits;
                    sb2_d   = stop_bits[1];
                    pen_d   = parity_enabled;
                    podd_d  = parity_bit;
                    acc_d   = parity_accept_errors;
                    idx_d   = '0;
                    data_d  = '0;
                    par_d   = 1'b0; zero_d = 1'b1; perr_d = 1'b0; ferr_d = 1'b0;
                end
            end
            S_START: begin
                if (s_vote && vote) state_d = S_IDLE;
                else if (bit_end)   state_d = S_DATA;
            end
            S_DATA: begin
                if (s_vote) begin
                    data_d[idx_q] = vote;
                    par_d  = par_q ^ vote;
                    zero_d = zero_q & ~vote;
                end
                if (bit_end) begin
                    if (idx_q == nb_q - 4'd1) begin
                        idx_d   = '0;
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (s_vote) begin
                    perr_d = ((par_q ^ vote) != podd_q);
                    zero_d = zero_q & ~vote;
                end
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (s_vote && last_stop) begin
                    // Frame is resolved mid last stop bit so a back-to-back start is caught
                    if (zero_q && !vote) begin
                        push      = 1'b1;
                        push_word = {3'b110, {pMAX_BITS{1'b0}}};
                        state_d   = S_WAITH;
                    end else if (perr_q && !acc_q) begin
                        discard = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        push      = 1'b1;
                        push_word = {1'b0, ferr_q | ~vote, perr_q, data_q};
                        state_d   = S_IDLE;
                    end
                end else begin
                    if (s_vote)  ferr_d = ferr_q | ~vote;
                    if (bit_end) idx_d  = idx_q + 4'd1;
                end
            end
            S_WAITH: if (rxd_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE; cnt_q <= '0; br_q <= 16'd4; nb_q <= 4'd5; idx_q <= '0;
            sb2_q <= 1'b0; pen_q <= 1'b0; podd_q <= 1'b0; acc_q <= 1'b0;
            s0_q <= 1'b1; s1_q <= 1'b1;
            par_q <= 1'b0; zero_q <= 1'b0; perr_q <= 1'b0; ferr_q <= 1'b0;
            data_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; br_q <= br_d; nb_q <= nb_d; idx_q <= idx_d;
            sb2_q <= sb2_d; pen_q <= pen_d; podd_q <= podd_d; acc_q <= acc_d;
            s0_q <= s0_d; s1_q <= s1_d;
            par_q <= par_d; zero_q <= zero_d; perr_q <= perr_d; ferr_q <= ferr_d;
            data_q <= data_d;
        end
    end

    logic [WW-1:0] mem_q [pFIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   fcnt_q;
    logic          full, pop, wr_en, ovf;
    logic          overrun_q;
    logic [15:0]   disc_q;

    assign full  = (fcnt_q == DEPTH);
    assign pop   = m_valid & m_ready;
    assign wr_en = push & (~full | pop);
    assign ovf   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0; rd_q <= '0; fcnt_q <= '0; overrun_q <= 1'b0; disc_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
            // A new loss wins over a coincident clear
            overrun_q <= ovf | (overrun_q & ~clear_overrun);
            if (discard && disc_q != 16'hFFFF) disc_q <= disc_q + 16'd1;
        end
    end

    assign m_valid             = (fcnt_q != '0);
    assign {m_flags, m_data}   = m_valid ? mem_q[rd_q] : '0;
    assign fifo_count          = fcnt_q;
    assign overrun             = overrun_q;
    assign discard_count       = disc_q;
    assign busy                = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are bit-banged on rxd, expected words
// are queued as each frame is sent and compared as they are popped from the FIFO.
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] bit_rate = 16'd16;
    logic [3:0]  data_bits = 4'd8;
    logic [1:0]  stop_bits = 2'd1;
    logic        parity_bit = 1'b0;
    logic        parity_enabled = 1'b0;
    logic        parity_accept_errors = 1'b0;
    logic        rxd = 1'b1;
    logic [8:0]  m_data;
    logic [2:0]  m_flags;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [4:0]  fifo_count;
    logic        overrun;
    logic        clear_overrun = 1'b0;
    logic [15:0] discard_count;
    logic        busy;

    int          br = 16;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [11:0] sb_q[$];

    uart_rx_fifo #(.pMAX_BITS(9), .pFIFO_DEPTH(16), .pSYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .bit_rate(bit_rate), .data_bits(data_bits),
        .stop_bits(stop_bits), .parity_bit(parity_bit), .parity_enabled(parity_enabled),
        .parity_accept_errors(parity_accept_errors), .rxd(rxd), .m_data(m_data),
        .m_flags(m_flags), .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count),
        .overrun(overrun), .clear_overrun(clear_overrun), .discard_count(discard_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic par_of(input logic [8:0] d, input int nb);
        logic p = 1'b0;
        for (int i = 0; i < nb; i++) p ^= d[i];
        return p;
    endfunction

    // glitch flips each data bit for one cycle in the middle of the sample window
    task automatic send(input logic [8:0] d, input int nb, input int pen, input logic pval,
                        input int ns, input bit glitch);
        rxd = 1'b0;
        tick(br);
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < br; c++) begin
                rxd = (glitch && c == br / 2) ? ~d[i] : d[i];
                tick();
            end
        end
        if (pen != 0) begin
            rxd = pval;
            tick(br);
        end
        rxd = 1'b1;
        tick(br * ns);
        tick(4);
    endtask

    task automatic pop_chk(input string tag);
        int          t = 0;
        logic [11:0] e;
        @(negedge clk);
        while (!m_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!m_valid) begin
            chk({tag, "_timeout_valid"}, 32'(m_valid), 32'd1);
        end else if (sb_q.size() == 0) begin
            chk({tag, "_unexpected_word"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_data"}, 32'(m_data), 32'(e[8:0]));
            chk({tag, "_flags"}, 32'(m_flags), 32'(e[11:9]));
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
        end
    endtask

    initial begin
        logic [8:0] d;
        tick(3);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_discard", 32'(discard_count), 32'd0);
        chk("rst_data", 32'({m_flags, m_data}), 32'd0);
        reset_n = 1'b1;
        tick(3);

        // 8N1 basic frame
        sb_q.push_back({3'b000, 9'h0A5});
        send(9'h0A5, 8, 0, 1'b0, 1, 1'b0);
        chk("t1_count", 32'(fifo_count), 32'd1);
        pop_chk("t1");
        chk("t1_count_after", 32'(fifo_count), 32'd0);

        // 8E1 with a wrong parity bit: discarded, then accepted and flagged
        parity_enabled = 1'b1;
        parity_bit = 1'b0;
        parity_accept_errors = 1'b0;
        send(9'h003, 8, 1, 1'b1, 1, 1'b0);
        chk("t2_discard", 32'(discard_count), 32'd1);
        chk("t2_count", 32'(fifo_count), 32'd0);
        parity_accept_errors = 1'b1;
        sb_q.push_back({3'b001, 9'h003});
        send(9'h003, 8, 1, 1'b1, 1, 1'b0);
        pop_chk("t2_acc");
        parity_enabled = 1'b0;
        parity_accept_errors = 1'b0;

        // 3-cycle low glitch in idle
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(3);
        chk("t3_busy_started", 32'(busy), 32'd1);
        tick(14);
        chk("t3_busy_cleared", 32'(busy), 32'd0);
        chk("t3_count", 32'(fifo_count), 32'd0);

        // Break: low for two frame times, then a normal frame
        sb_q.push_back({3'b110, 9'h000});
        rxd = 1'b0;
        tick(2 * 10 * br);
        chk("t4_busy_waith", 32'(busy), 32'd1);
        rxd = 1'b1;
        tick(5);
        chk("t4_busy_idle", 32'(busy), 32'd0);
        pop_chk("t4_brk");
        sb_q.push_back({3'b000, 9'h055});
        send(9'h055, 8, 0, 1'b0, 1, 1'b0);
        pop_chk("t4_55");

        // Fill past capacity with m_ready low
        for (int i = 0; i < 17; i++) begin
            d = 9'((i * 37 + 11) & 8'hFF);
            if (i < 16) sb_q.push_back({3'b000, d});
            send(d, 8, 0, 1'b0, 1, 1'b0);
        end
        chk("t5_count_full", 32'(fifo_count), 32'd16);
        chk("t5_overrun_set", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("t5_overrun_clr", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("t5_w%0d", i));
        chk("t5_count_empty", 32'(fifo_count), 32'd0);

        // 9 data bits, odd parity, 2 stops, glitch on every data bit
        data_bits = 4'd9;
        stop_bits = 2'd2;
        parity_enabled = 1'b1;
        parity_bit = 1'b1;
        sb_q.push_back({3'b000, 9'h1FF});
        send(9'h1FF, 9, 1, ~par_of(9'h1FF, 9), 2, 1'b1);
        pop_chk("t6_glitch");

        // Reset in the middle of a frame
        rxd = 1'b0;
        tick(3 * br);
        reset_n = 1'b0;
        tick(2);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_count", 32'(fifo_count), 32'd0);
        chk("t6_rst_discard", 32'(discard_count), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        rxd = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(300);
        chk("t6_post_count", 32'(fifo_count), 32'd0);
        chk("t6_post_valid", 32'(m_valid), 32'd0);
        chk("t6_post_busy", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
